// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the shared memory port.
// "slave" is the arbiter's view; "master" is the core/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              i_req;
  logic [AWIDTH-1:0] i_addr;
  logic [DWIDTH-1:0] i_rdata;
  logic              i_ack;

  logic              d_req;
  logic              d_we;
  logic [2:0]        d_size;
  logic [AWIDTH-1:0] d_addr;
  logic [DWIDTH-1:0] d_wdata;
  logic [DWIDTH-1:0] d_rdata;
  logic              d_ack;

  logic              m_req;
  logic              m_we;
  logic [2:0]        m_size;
  logic [AWIDTH-1:0] m_addr;
  logic [DWIDTH-1:0] m_wdata;
  logic [DWIDTH-1:0] m_rdata;
  logic              m_ready;

  logic              stall_if;
  logic              stall_mem;
  logic              err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata, m_ready,
    output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_size, m_addr, m_wdata,
           stall_if, stall_mem, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata, m_ready,
    input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_size, m_addr, m_wdata,
           stall_if, stall_mem, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// with registered acks/read data, pipeline stall outputs and a sticky timeout error.
module mem_port_arbiter #(
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int              WW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0]   WAIT_LAST = (MAX_WAIT > 0) ? WW'(MAX_WAIT - 1) : '0;
  localparam logic            TO_EN     = (MAX_WAIT > 0);
  localparam logic            SEL_I     = 1'b0;
  localparam logic            SEL_D     = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              req_we_q;
  logic [2:0]        req_size_q;
  logic [AWIDTH-1:0] req_addr_q;
  logic [DWIDTH-1:0] req_wdata_q;
  logic              last_grant_q;
  logic              done_last_q;
  logic [WW-1:0]     wait_cnt_q;
  logic              i_ack_q, d_ack_q, err_q;
  logic [DWIDTH-1:0] i_rdata_q, d_rdata_q;

  logic              eff_i, eff_d, prefer_d;
  logic              capture, grant_d;
  logic              granted, timeout, done;
  logic [DWIDTH-1:0] rdata_in;
  logic              m_req_c, stall_if_c, stall_mem_c;

  // A requester whose ack is high this cycle is still holding its old request.
  assign eff_i    = bus.i_req & ~i_ack_q;
  assign eff_d    = bus.d_req & ~d_ack_q;
  // Grant and completion histories agree whenever IDLE is reached.
  assign prefer_d = (last_grant_q == SEL_I) & (done_last_q == SEL_I);
  assign granted  = (state_q != S_IDLE);
  assign timeout  = TO_EN & granted & ~bus.m_ready & (wait_cnt_q == WAIT_LAST);
  assign done     = granted & (bus.m_ready | timeout);
  assign rdata_in = timeout ? '0 : bus.m_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (eff_i | eff_d) begin
          capture = 1'b1;
          grant_d = eff_d & (~eff_i | prefer_d);
          state_d = grant_d ? S_GRANT_D : S_GRANT_I;
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_req_c     = granted;
    stall_if_c  = bus.i_req & ~i_ack_q;
    stall_mem_c = bus.d_req & ~d_ack_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_we_q     <= 1'b0;
      req_size_q   <= '0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      last_grant_q <= SEL_D;
      done_last_q  <= SEL_D;
      wait_cnt_q   <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      i_ack_q <= done & (state_q == S_GRANT_I);
      d_ack_q <= done & (state_q == S_GRANT_D);
      if (capture) begin
        last_grant_q <= grant_d;
        wait_cnt_q   <= '0;
        if (grant_d) begin
          req_we_q    <= bus.d_we;
          req_size_q  <= bus.d_size;
          req_addr_q  <= bus.d_addr;
          req_wdata_q <= bus.d_wdata;
        end else begin
          req_we_q    <= 1'b0;
          req_size_q  <= 3'b010;
          req_addr_q  <= bus.i_addr;
          req_wdata_q <= '0;
        end
      end else if (granted && !bus.m_ready) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (done) begin
        done_last_q <= (state_q == S_GRANT_D);
        if (state_q == S_GRANT_I)              i_rdata_q <= rdata_in;
        if (state_q == S_GRANT_D && !req_we_q) d_rdata_q <= rdata_in;
      end
      if (timeout) err_q <= 1'b1;
    end
  end

  assign bus.m_req     = m_req_c;
  assign bus.m_we      = req_we_q;
  assign bus.m_size    = req_size_q;
  assign bus.m_addr    = req_addr_q;
  assign bus.m_wdata   = req_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall_if  = stall_if_c;
  assign bus.stall_mem = stall_mem_c;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, round-robin, store/load data, timeout, reset abort.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input bit is_d, input logic [31:0] addr, input logic [31:0] rd,
                        input string tag);
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 3'b010; bus.d_addr = addr;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    tick();
    chk({tag, ".m_req"}, bus.m_req, 1);
    chk({tag, ".m_addr"}, bus.m_addr, addr);
    bus.m_ready = 1'b1; bus.m_rdata = rd;
    tick();
    chk({tag, ".ack"}, is_d ? bus.d_ack : bus.i_ack, 1);
    chk({tag, ".other_ack"}, is_d ? bus.i_ack : bus.d_ack, 0);
    chk({tag, ".rdata"}, is_d ? bus.d_rdata : bus.i_rdata, rd);
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.m_ready = 1'b0;
    tick();
    chk({tag, ".ack_pulse"}, is_d ? bus.d_ack : bus.i_ack, 0);
  endtask

  initial begin
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_size = '0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.m_rdata = '0; bus.m_ready = 0;

    #1;
    chk("rst.m_req", bus.m_req, 0);
    chk("rst.i_ack", bus.i_ack, 0);
    chk("rst.d_ack", bus.d_ack, 0);
    chk("rst.err", bus.err, 0);
    chk("rst.m_addr", bus.m_addr, 0);
    chk("rst.i_rdata", bus.i_rdata, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("idle.m_req", bus.m_req, 0);

    // Zero-wait fetch
    bus.i_req = 1; bus.i_addr = 32'h100;
    #1;
    chk("t1.c0.stall_if", bus.stall_if, 1);
    chk("t1.c0.m_req", bus.m_req, 0);
    tick();
    chk("t1.c1.m_req", bus.m_req, 1);
    chk("t1.c1.m_addr", bus.m_addr, 32'h100);
    chk("t1.c1.m_we", bus.m_we, 0);
    chk("t1.c1.m_size", bus.m_size, 3'b010);
    chk("t1.c1.stall_if", bus.stall_if, 1);
    bus.m_ready = 1; bus.m_rdata = 32'h00500093;
    tick();
    chk("t1.c2.i_ack", bus.i_ack, 1);
    chk("t1.c2.i_rdata", bus.i_rdata, 32'h00500093);
    chk("t1.c2.m_req", bus.m_req, 0);
    chk("t1.c2.stall_if", bus.stall_if, 0);
    bus.i_req = 0; bus.m_ready = 0; bus.m_rdata = '0;
    tick();
    chk("t1.c3.i_ack", bus.i_ack, 0);

    // Load to give d_rdata a known value
    single(1'b1, 32'h300, 32'hCAFEF00D, "ld0");

    // Simultaneous fetch + store
    bus.i_req = 1; bus.i_addr = 32'h104;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF; bus.d_size = 3'b010;
    tick();
    chk("t2.c1.m_addr", bus.m_addr, 32'h104);
    chk("t2.c1.m_we", bus.m_we, 0);
    bus.m_ready = 1; bus.m_rdata = 32'h00000013;
    tick();
    chk("t2.c2.i_ack", bus.i_ack, 1);
    chk("t2.c2.d_ack", bus.d_ack, 0);
    chk("t2.c2.i_rdata", bus.i_rdata, 32'h00000013);
    bus.i_req = 0; bus.m_ready = 0;
    tick();
    chk("t2.c3.m_req", bus.m_req, 1);
    chk("t2.c3.m_we", bus.m_we, 1);
    chk("t2.c3.m_addr", bus.m_addr, 32'h200);
    chk("t2.c3.m_wdata", bus.m_wdata, 32'hDEADBEEF);
    chk("t2.c3.m_size", bus.m_size, 3'b010);
    bus.m_ready = 1; bus.m_rdata = 32'h11111111;
    tick();
    chk("t2.c4.d_ack", bus.d_ack, 1);
    chk("t2.c4.d_rdata", bus.d_rdata, 32'hCAFEF00D);
    bus.d_req = 0; bus.d_we = 0; bus.m_ready = 0;
    tick();

    // Both held: grants alternate I, D, I, D
    bus.i_req = 1; bus.i_addr = 32'h400;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500;
    bus.m_ready = 1; bus.m_rdata = 32'h1000;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c % 2 == 1) begin
        chk($sformatf("t3.c%0d.m_req", c), bus.m_req, 1);
        chk($sformatf("t3.c%0d.m_addr", c), bus.m_addr, (c % 4 == 1) ? 32'h400 : 32'h500);
      end else begin
        chk($sformatf("t3.c%0d.m_req", c), bus.m_req, 0);
        if (c % 4 == 2) chk($sformatf("t3.c%0d.i_rdata", c), bus.i_rdata, 32'h1000 + c - 1);
        else            chk($sformatf("t3.c%0d.d_rdata", c), bus.d_rdata, 32'h1000 + c - 1);
      end
      chk($sformatf("t3.c%0d.i_ack", c), bus.i_ack, (c % 4 == 2) ? 1 : 0);
      chk($sformatf("t3.c%0d.d_ack", c), bus.d_ack, (c % 4 == 0) ? 1 : 0);
      bus.m_rdata = 32'h1000 + c;
      if (c == 6) bus.i_req = 0;
      if (c == 8) begin bus.d_req = 0; bus.m_ready = 0; end
    end
    tick();
    chk("t3.c9.m_req", bus.m_req, 0);
    chk("t3.c9.d_ack", bus.d_ack, 0);

    // Load with three wait cycles
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h600;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("t4.c%0d.m_req", c), bus.m_req, 1);
      chk($sformatf("t4.c%0d.d_ack", c), bus.d_ack, 0);
      if (c == 1) chk("t4.c1.stall_mem", bus.stall_mem, 1);
      if (c == 4) begin bus.m_ready = 1; bus.m_rdata = 32'h12345678; end
    end
    tick();
    chk("t4.c5.d_ack", bus.d_ack, 1);
    chk("t4.c5.d_rdata", bus.d_rdata, 32'h12345678);
    chk("t4.c5.err", bus.err, 0);
    chk("t4.c5.stall_mem", bus.stall_mem, 0);
    bus.d_req = 0; bus.m_ready = 0;
    tick();

    // Timeout on a fetch
    bus.i_req = 1; bus.i_addr = 32'h700;
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk($sformatf("t5.c%0d.m_req", c), bus.m_req, 1);
      chk($sformatf("t5.c%0d.i_ack", c), bus.i_ack, 0);
    end
    tick();
    chk("t5.c16.i_ack", bus.i_ack, 1);
    chk("t5.c16.i_rdata", bus.i_rdata, 0);
    chk("t5.c16.err", bus.err, 1);
    bus.i_req = 0;
    tick();
    chk("t5.c17.i_ack", bus.i_ack, 0);
    chk("t5.c17.m_req", bus.m_req, 0);
    single(1'b1, 32'h800, 32'h55AA55AA, "post_to");
    chk("post_to.err", bus.err, 1);

    // Reset during a data grant
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'hA00;
    tick();
    chk("t6.c1.m_req", bus.m_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6.rst.m_req", bus.m_req, 0);
    chk("t6.rst.d_ack", bus.d_ack, 0);
    chk("t6.rst.i_ack", bus.i_ack, 0);
    chk("t6.rst.err", bus.err, 0);
    bus.d_req = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("t6.rel.m_req", bus.m_req, 0);
    chk("t6.rel.d_ack", bus.d_ack, 0);
    single(1'b0, 32'h900, 32'h0BADCAFE, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
